// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and byte-lane ordering.
// The fetch and memory blocks use the same lane order, so this package is the single source for it.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // 1: byte k of the stream lands in bits [8k+7:8k] (little-endian packing)
    localparam bit LANE_LE = 1'b1;

    function automatic int lane_of(input int k, input int bpw);
        return LANE_LE ? k : (bpw - 1 - k);
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a byte stream into WIDTH-bit words: byte counter plus lane-insert register.
// word_full flags the byte that completes the current word; clr restarts packing at lane 0.
module imem_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             byte_vld,
    input  logic [7:0]       byte_in,
    output logic             word_full,
    output logic [WIDTH-1:0] word
);
    localparam int BPW = WIDTH / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0] cnt;

    assign word_full = byte_vld && (cnt == CW'(BPW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            word <= '0;
        end else if (clr) begin
            cnt  <= '0;
            word <= '0;
        end else if (byte_vld) begin
            word[8*lane_of(int'(cnt), BPW) +: 8] <= byte_in;
            // explicit wrap keeps non-power-of-two BPW correct
            cnt <= word_full ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Write-side loader for the instruction store: packs host bytes into words and
// writes them to consecutive word addresses starting at base_addr.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              wrapped
);
    state_t            state, state_n;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0]   remaining;
    logic              accept, start_ok, clr, word_full, at_top;
    logic [WIDTH-1:0]  word;

    assign accept   = in_valid && in_ready && !abort;
    assign start_ok = (state == S_IDLE) && start && !abort;
    assign clr      = abort || start_ok;
    assign at_top   = (cur_addr == ADDR_W'(DEPTH - 1));

    imem_byte_packer #(.WIDTH(WIDTH)) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .byte_vld  (accept),
        .byte_in   (in_data),
        .word_full (word_full),
        .word      (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (start_ok) state_n = (word_count == '0) ? S_DONE : S_LOAD;
            S_LOAD:  if (accept && word_full) state_n = S_WRITE;
            S_WRITE: state_n = (remaining == (ADDR_W+1)'(1)) ? S_DONE : S_LOAD;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (abort) state_n = S_IDLE;
    end

    // in_ready follows the next state so a byte is never accepted in the WRITE cycle;
    // the other status outputs report the state just left, gated by abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrapped   <= 1'b0;
            cur_addr  <= '0;
            remaining <= '0;
        end else begin
            in_ready <= (state_n == S_LOAD);
            busy     <= !abort && ((state == S_LOAD) || (state == S_WRITE));
            done     <= !abort && (state == S_DONE);
            mem_we   <= 1'b0;
            if (start_ok) begin
                cur_addr  <= base_addr;
                remaining <= word_count;
                wrapped   <= 1'b0;
            end
            if ((state == S_WRITE) && !abort) begin
                mem_we    <= 1'b1;
                mem_addr  <= cur_addr;
                mem_wdata <= word;
                remaining <= remaining - (ADDR_W+1)'(1);
                cur_addr  <= at_top ? '0 : cur_addr + ADDR_W'(1);
                if (at_top) wrapped <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: models the instruction memory and a write log,
// drives byte streams and checks writes, done timing, wrap and abort behaviour.
module tb_imem_loader;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   word_count = '0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_ready, mem_we, busy, done, wrapped;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;

    int pass_cnt = 0;
    int check_cnt = 0;
    int dcnt = 0;

    logic [WIDTH-1:0]  mem [0:DEPTH-1];
    logic [ADDR_W-1:0] log_addr [$];
    logic [WIDTH-1:0]  log_data [$];
    logic [7:0]        bq [$];

    imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .wrapped    (wrapped)
    );

    always #5 clk = ~clk;

    // instruction memory model and write/done monitors
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end
        if (done) dcnt <= dcnt + 1;
    end

    task automatic start_load(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
        @(negedge clk);
        base_addr = b; word_count = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feeds every byte of bq; entered and left on a negedge.
    task automatic feed(input bit stall, output bit ok);
        int idx = 0;
        int guard = 0;
        bit acc;
        while (idx < bq.size() && guard < 400) begin
            in_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_data  = in_valid ? bq[idx] : 8'($urandom_range(0, 255));
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
            guard++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        ok = (idx == bq.size());
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                cyc = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bit ok;
        int c, w0;
        #1;
        check_cnt++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, wrapped} !== '0)
            $display("FAIL reset_init: outputs=%h required 0",
                     {in_ready, mem_we, mem_addr, mem_wdata, busy, done, wrapped});
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        start_load(10'h010, 11'd1);
        bq = '{8'hAA, 8'hBB};
        feed(1'b0, ok);
        check_cnt++;
        if (!(in_ready === 1'b1 && busy === 1'b1))
            $display("FAIL reset_midload_pre: in_ready=%b busy=%b required 1 1", in_ready, busy);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        check_cnt++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, wrapped} !== '0)
            $display("FAIL reset_async: outputs=%h required 0",
                     {in_ready, mem_we, mem_addr, mem_wdata, busy, done, wrapped});
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        w0 = log_addr.size();
        start_load(10'h010, 11'd1);
        bq = '{8'h11, 8'h22, 8'h33, 8'h44};
        feed(1'b0, ok);
        wait_done(c);
        check_cnt++;
        if (!ok || c < 0 || log_addr.size() - w0 != 1 || mem[10'h010] !== 32'h44332211)
            $display("FAIL reset_reload: ok=%0d done_cyc=%0d writes=%0d mem[010]=%h required 1 >=0 1 44332211",
                     ok, c, log_addr.size() - w0, mem[10'h010]);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic run_two_words(input bit stall, input string tag);
        bit ok;
        int c, w0, d0;
        w0 = log_addr.size(); d0 = dcnt;
        start_load(10'h004, 11'd2);
        bq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        feed(stall, ok);
        wait_done(c);
        check_cnt++;
        if (!ok || c != 2)
            $display("FAIL %s_done_latency: fed=%0d cycles=%0d required 1 2", tag, ok, c);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (done !== 1'b0 || dcnt - d0 != 1 || busy !== 1'b0)
            $display("FAIL %s_done_pulse: done=%b pulses=%0d busy=%b required 0 1 0", tag, done, dcnt - d0, busy);
        else pass_cnt++;
        check_cnt++;
        if (log_addr.size() - w0 != 2)
            $display("FAIL %s_write_count: writes=%0d required 2", tag, log_addr.size() - w0);
        else if (log_addr[w0] !== 10'h004 || log_data[w0] !== 32'h12345678 ||
                 log_addr[w0+1] !== 10'h005 || log_data[w0+1] !== 32'hDEADBEEF)
            $display("FAIL %s_write_list: %h=%h %h=%h required 004=12345678 005=deadbeef",
                     tag, log_addr[w0], log_data[w0], log_addr[w0+1], log_data[w0+1]);
        else pass_cnt++;
        check_cnt++;
        if (mem[10'h004] !== 32'h12345678 || mem[10'h005] !== 32'hDEADBEEF)
            $display("FAIL %s_mem: mem[004]=%h mem[005]=%h required 12345678 deadbeef",
                     tag, mem[10'h004], mem[10'h005]);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        run_two_words(1'b0, "basic");
        check_cnt++;
        if (mem_we !== 1'b0 || mem_addr !== 10'h005 || mem_wdata !== 32'hDEADBEEF)
            $display("FAIL basic_hold: we=%b addr=%h data=%h required 0 005 deadbeef", mem_we, mem_addr, mem_wdata);
        else pass_cnt++;
    endtask

    task automatic test_stalls();
        mem[10'h004] = '0;
        mem[10'h005] = '0;
        run_two_words(1'b1, "stalls");
    endtask

    task automatic test_wrap();
        bit ok;
        int c, w0;
        w0 = log_addr.size();
        start_load(10'h3FF, 11'd2);
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        feed(1'b0, ok);
        wait_done(c);
        check_cnt++;
        if (log_addr.size() - w0 != 2)
            $display("FAIL wrap_write_count: writes=%0d required 2", log_addr.size() - w0);
        else if (log_addr[w0] !== 10'h3FF || log_data[w0] !== 32'h04030201 ||
                 log_addr[w0+1] !== 10'h000 || log_data[w0+1] !== 32'h08070605)
            $display("FAIL wrap_write_list: %h=%h %h=%h required 3ff=04030201 000=08070605",
                     log_addr[w0], log_data[w0], log_addr[w0+1], log_data[w0+1]);
        else pass_cnt++;
        check_cnt++;
        if (c < 0 || wrapped !== 1'b1)
            $display("FAIL wrap_flag: done_cyc=%0d wrapped=%b required >=0 1", c, wrapped);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_zero_ignored();
        bit ok;
        int c, w0, d0;
        w0 = log_addr.size(); d0 = dcnt;
        start_load(10'h055, 11'd0);
        check_cnt++;
        if (done !== 1'b0 || wrapped !== 1'b0)
            $display("FAIL zero_first_cycle: done=%b wrapped=%b required 0 0", done, wrapped);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (done !== 1'b1) $display("FAIL zero_done: done=%b required 1", done);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (done !== 1'b0 || dcnt - d0 != 1 || log_addr.size() != w0)
            $display("FAIL zero_after: done=%b pulses=%0d writes=%0d required 0 1 0",
                     done, dcnt - d0, log_addr.size() - w0);
        else pass_cnt++;
        w0 = log_addr.size();
        start_load(10'h020, 11'd1);
        base_addr = 10'h100; word_count = 11'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        feed(1'b0, ok);
        wait_done(c);
        check_cnt++;
        if (c < 0 || log_addr.size() - w0 != 1)
            $display("FAIL busy_start_count: done_cyc=%0d writes=%0d required >=0 1", c, log_addr.size() - w0);
        else if (log_addr[w0] !== 10'h020 || log_data[w0] !== 32'hD4C3B2A1)
            $display("FAIL busy_start_write: %h=%h required 020=d4c3b2a1", log_addr[w0], log_data[w0]);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_abort();
        bit ok;
        int c, w0, d0;
        w0 = log_addr.size(); d0 = dcnt;
        start_load(10'h040, 11'd2);
        bq = '{8'h99, 8'h88};
        feed(1'b0, ok);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (4) @(negedge clk);
        check_cnt++;
        if (log_addr.size() != w0 || dcnt != d0 || busy !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL abort_load: writes=%0d pulses=%0d busy=%b in_ready=%b required 0 0 0 0",
                     log_addr.size() - w0, dcnt - d0, busy, in_ready);
        else pass_cnt++;
        start_load(10'h041, 11'd1);
        bq = '{8'h11, 8'h22, 8'h33, 8'h44};
        feed(1'b0, ok);
        wait_done(c);
        check_cnt++;
        if (c < 0 || log_addr.size() - w0 != 1 || mem[10'h041] !== 32'h44332211)
            $display("FAIL abort_fresh: done_cyc=%0d writes=%0d mem[041]=%h required >=0 1 44332211",
                     c, log_addr.size() - w0, mem[10'h041]);
        else pass_cnt++;
        @(negedge clk);
        w0 = log_addr.size(); d0 = dcnt;
        start_load(10'h3FF, 11'd2);
        bq = '{8'h10, 8'h20, 8'h30, 8'h40};
        feed(1'b0, ok);
        bq = '{8'h50, 8'h60, 8'h70, 8'h80};
        feed(1'b0, ok);
        check_cnt++;
        if (in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL write_cycle: in_ready=%b busy=%b required 0 1", in_ready, busy);
        else pass_cnt++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_cnt++;
        if (mem_we !== 1'b0) $display("FAIL abort_write_we: mem_we=%b required 0", mem_we);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        check_cnt++;
        if (log_addr.size() - w0 != 1 || dcnt != d0 || wrapped !== 1'b1 || busy !== 1'b0)
            $display("FAIL abort_write: writes=%0d pulses=%0d wrapped=%b busy=%b required 1 0 1 0",
                     log_addr.size() - w0, dcnt - d0, wrapped, busy);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_wrap();
        test_zero_ignored();
        test_abort();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
